// File: rtl/tick_timer_if.sv
// ============================================================================
// Module   : tick_timer_if
// Brief    : Control/status bundle between a tick_timer and its controller.
//            Optional ack/overrun pair present when TICK_TIMER_OVERRUN_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_timer_if #(
    parameter int W = 8
) ();
    logic         tick;
    logic         start;
    logic [W-1:0] load_val;
    logic         periodic;
    logic         pause;
    logic         stop;
    logic         busy;
    logic         done;
    logic [W-1:0] count;
`ifdef TICK_TIMER_OVERRUN_EN
    logic         ack;
    logic         overrun;
`endif

    modport master (
        output tick,
        output start,
        output load_val,
        output periodic,
        output pause,
        output stop,
`ifdef TICK_TIMER_OVERRUN_EN
        output ack,
        input  overrun,
`endif
        input  busy,
        input  done,
        input  count
    );

    modport slave (
        input  tick,
        input  start,
        input  load_val,
        input  periodic,
        input  pause,
        input  stop,
`ifdef TICK_TIMER_OVERRUN_EN
        input  ack,
        output overrun,
`endif
        output busy,
        output done,
        output count
    );
endinterface

`default_nettype wire

// File: rtl/tick_timer.sv
// ============================================================================
// Module   : tick_timer
// Brief    : Tick-driven countdown timer, one-shot or auto-reload, with pause
//            and stop. Optional overrun detection: TICK_TIMER_OVERRUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer #(
    parameter int W = 8
) (
    input  wire logic    clk,
    input  wire logic    reset,
    tick_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [W-1:0] C_ONE  = W'(1);
    localparam logic [W-1:0] C_ZERO = '0;

    state_t       r_state;
    logic [W-1:0] r_count;
    logic [W-1:0] r_reload;
    logic         r_mode;
    logic         r_done;

    logic         w_abort;
    logic         w_load;
    logic         w_expire;

    // Decode the per-cycle priority once so the optional overrun logic sees
    // exactly the same expiry event as the main state machine.
    always_comb begin
        w_abort  = 1'b0;
        w_load   = 1'b0;
        w_expire = 1'b0;
        if (bus.stop && (r_state != ST_IDLE)) begin
            w_abort = 1'b1;
        end else if (bus.start && (bus.load_val != C_ZERO)) begin
            w_load = 1'b1;
        end else if ((r_state == ST_RUN) && !bus.pause && bus.tick
                     && (r_count == C_ONE)) begin
            w_expire = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= C_ZERO;
            r_reload <= C_ZERO;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_count <= C_ZERO;
            end else if (w_load) begin
                r_count  <= bus.load_val;
                r_reload <= bus.load_val;
                r_mode   <= bus.periodic;
                r_state  <= bus.pause ? ST_PAUSED : ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (bus.pause) begin
                            r_state <= ST_PAUSED;
                        end else if (w_expire) begin
                            r_done <= 1'b1;
                            if (r_mode) begin
                                r_count <= r_reload;
                            end else begin
                                r_count <= C_ZERO;
                                r_state <= ST_IDLE;
                            end
                        end else if (bus.tick && (r_count > C_ONE)) begin
                            r_count <= r_count - C_ONE;
                        end
                    end
                    ST_PAUSED: begin
                        if (!bus.pause) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = r_done;
    assign bus.count = r_count;

`ifdef TICK_TIMER_OVERRUN_EN
    logic r_pending;
    logic r_overrun;

    // An expiry coinciding with ack re-arms pending but is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (bus.ack) begin
                r_pending <= 1'b0;
            end

            if (w_expire && r_mode && r_pending && !bus.ack) begin
                r_overrun <= 1'b1;
            end else if (bus.ack && !w_expire) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.overrun = r_overrun;
`endif

endmodule

`default_nettype wire
